// File: rtl/spi_master_seq_pkg.sv
// spi_master_seq_pkg
// Shared definitions for the SPI master sequencer slice.
//   spi_state_e  : sequencer states IDLE -> SETUP -> XFER -> HOLD -> GAP
//   MODE0..MODE3 : SPI mode encodings as {cpol, cpha}
//   edge_cnt_w() : width of a counter holding 0..2*DATA_W SCLK edges
//   cnt_w()      : width of a counter holding 0..n-1 (minimum 1 bit)
package spi_master_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic int edge_cnt_w(input int data_w);
      return $clog2(2 * data_w + 1);
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if
// Bundles the user-side command signals and the SPI pins of one sequencer.
//   start, cpol, cpha, cs_sel, tx_data : transfer request from command logic
//   busy, done, rx_data                : transfer status / received word
//   sclk, mosi, cs_n, miso             : SPI pins
// Modports:
//   master : the sequencer's view (drives status and SPI outputs)
//   slave  : the user/pin side view (drives requests and miso)
interface spi_master_seq_if #(
   parameter int DATA_W = 8,
   parameter int N_CS   = 1,
   parameter int CS_W   = 1
);

   logic              start;
   logic              cpol;
   logic              cpha;
   logic [CS_W-1:0]   cs_sel;
   logic [DATA_W-1:0] tx_data;
   logic              miso;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;
   logic              sclk;
   logic              mosi;
   logic [N_CS-1:0]   cs_n;

   modport master (
      input  start, cpol, cpha, cs_sel, tx_data, miso,
      output busy, done, rx_data, sclk, mosi, cs_n
   );

   modport slave (
      output start, cpol, cpha, cs_sel, tx_data, miso,
      input  busy, done, rx_data, sclk, mosi, cs_n
   );

endinterface

// File: rtl/spi_master_seq_tick_gen.sv
// spi_master_seq_tick_gen
// Divides clk into SCLK half-period ticks.
//   clk, rst : system clock, asynchronous active-high reset
//   restart  : forces the count back to zero so the next tick lands
//              exactly HALF_DIV cycles later
//   tick     : high for one clk cycle out of every HALF_DIV
//              (permanently high when HALF_DIV is 1)
module spi_master_seq_tick_gen
   import spi_master_seq_pkg::*;
#(
   parameter int HALF_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = cnt_w(HALF_DIV);
   localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-HALF_DIV counter. A restart realigns it to the
   // start of a transfer; otherwise it wraps after the tick cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq
// SPI master sequencer: one DATA_W-bit full-duplex transfer per start,
// any of the four SPI modes, programmable SCLK divider, N_CS chip selects.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : spi_master_seq_if master modport
//              start/cpol/cpha/cs_sel/tx_data in, busy/done/rx_data out,
//              sclk/mosi/cs_n out, miso in
// Frame timing in HALF_DIV ticks after the accept edge T0:
//   SETUP 1 tick, XFER 2*DATA_W ticks, HOLD 1 tick, GAP 1 tick.
module spi_master_seq
   import spi_master_seq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int HALF_DIV = 1,
   parameter int N_CS     = 1,
   parameter int CS_W     = 1
) (
   input logic              clk,
   input logic              rst,
   spi_master_seq_if.master bus
);

   localparam int            EW        = edge_cnt_w(DATA_W);
   localparam logic [EW-1:0] N_EDGES   = EW'(2 * DATA_W);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

   spi_state_e        state;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] rx_q;
   logic [EW-1:0]     edge_cnt;
   logic [N_CS-1:0]   cs_n_q;
   logic              busy_q;
   logic              done_q;
   logic              sclk_q;
   logic              mosi_q;

   logic              tick;
   logic              accept;
   logic              is_edge;
   logic              leading;
   logic              sample_now;
   logic              shift_now;

   // One-hot active-low decode; an out-of-range index selects nobody.
   function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [N_CS-1:0] v;
      v = '1;
      for (int i = 0; i < N_CS; i++) begin
         if (sel == CS_W'(i)) begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   spi_master_seq_tick_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .tick    (tick)
   );

   // A start is taken in IDLE, or in the last GAP tick so that a held
   // start produces back-to-back frames with a one-tick CS-high gap.
   always_comb begin
      accept = 1'b0;
      if (bus.start) begin
         if (state == IDLE) begin
            accept = 1'b1;
         end else if ((state == GAP) && tick) begin
            accept = 1'b1;
         end
      end
   end

   // Decide what the current tick does to the SCLK line. The SETUP tick is
   // edge 0; XFER ticks are edges 1..2*DATA_W-1 and then one idle tick.
   // Even edges lead, odd edges trail. CPHA=0 samples on leading edges and
   // shifts on trailing ones (the final trailing edge has nothing left to
   // shift); CPHA=1 shifts on leading edges and samples on trailing ones.
   always_comb begin
      is_edge    = 1'b0;
      sample_now = 1'b0;
      shift_now  = 1'b0;
      leading    = ~edge_cnt[0];
      if (tick && ((state == SETUP) || ((state == XFER) && (edge_cnt != N_EDGES)))) begin
         is_edge = 1'b1;
      end
      if (is_edge) begin
         unique case (mode_q)
            MODE0, MODE2: begin
               sample_now = leading;
               shift_now  = ~leading && (edge_cnt != LAST_EDGE);
            end
            MODE1, MODE3: begin
               sample_now = ~leading;
               shift_now  = leading;
            end
         endcase
      end
   end

   // Main sequencer. All pin and status outputs are registered here. The
   // accept branch sits last so that a start in the done cycle overrides the
   // return-to-IDLE while still letting done and rx_data update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mode_q   <= MODE0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_q     <= '0;
         edge_cnt <= '0;
         cs_n_q   <= '1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (is_edge) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + EW'(1);
            if (sample_now) begin
               rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
            end
            if (shift_now) begin
               tx_sr <= tx_sr << 1;
               if (mode_q[0]) begin
                  mosi_q <= tx_sr[DATA_W-1];
               end else begin
                  mosi_q <= tx_sr[DATA_W-2];
               end
            end
         end

         unique case (state)
            IDLE: begin
            end
            SETUP: begin
               if (tick) begin
                  state <= XFER;
               end
            end
            XFER: begin
               if (tick && (edge_cnt == N_EDGES)) begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (tick) begin
                  sclk_q <= mode_q[1];
                  cs_n_q <= '1;
                  state  <= GAP;
               end
            end
            GAP: begin
               if (tick) begin
                  done_q <= 1'b1;
                  rx_q   <= rx_sr;
                  busy_q <= 1'b0;
                  mosi_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (accept) begin
            mode_q   <= {bus.cpol, bus.cpha};
            tx_sr    <= bus.tx_data;
            cs_n_q   <= cs_decode(bus.cs_sel);
            sclk_q   <= bus.cpol;
            busy_q   <= 1'b1;
            edge_cnt <= '0;
            state    <= SETUP;
            if (bus.cpha) begin
               mosi_q <= 1'b0;
            end else begin
               mosi_q <= bus.tx_data[DATA_W-1];
            end
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;
   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.cs_n    = cs_n_q;

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Parametrised successor to the fixed mode-0 SPI sequencer.
- Generates CS, SCLK and MOSI for one DATA_W-bit transfer and captures MISO into a parallel word.
- Supports all four SPI modes (cpol/cpha selectable per transfer), a programmable SCLK divider and N_CS chip selects.
- Sits between the user-side command logic (start/tx_data/rx_data) and the SPI pins.

Parameters:
- DATA_W, 8: bits per transfer, ≥2.
- HALF_DIV, 1: clk cycles per SCLK half-period, ≥1.
- N_CS, 1: number of chip-select outputs, ≥1.
- CS_W, 1: width of cs_sel, ≥ clog2(N_CS), min 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a transfer; sampled only in IDLE.
- cpol  in  1  clock polarity; latched at start accept.
- cpha  in  1  clock phase; latched at start accept.
- cs_sel  in  CS_W  target slave index; latched at start accept.
- tx_data  in  DATA_W  word to send, MSB first; latched at start accept.
- miso  in  1  serial data from slave.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse when rx_data is valid.
- rx_data  out  DATA_W  last received word; holds until the next done.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data to slave.
- cs_n  out  N_CS  active-low chip selects.

Behaviour:
- Reset values, applied immediately and asynchronously, including mid-transfer: state=IDLE, busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1s, latched cpol/cpha=0.
- All timing is derived from a HALF_DIV tick counter: one tick per HALF_DIV clk cycles. The counter restarts at start accept.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. Cycle T0 is the clk edge that samples start=1 in IDLE.
- IDLE:
  - sclk = latched cpol; mosi=0; cs_n all high.
  - start=1 latches cpol, cpha, cs_sel and tx_data, sets busy=1 and enters SETUP at T0.
- SETUP (1 tick):
  - cs_n[cs_sel]=0; sclk = new cpol.
  - CPHA=0: mosi=tx_data[DATA_W-1] from T0.
  - CPHA=1: mosi is unchanged until the first edge.
- XFER (2*DATA_W ticks):
  - SCLK edge k (k=0..2*DATA_W-1) toggles sclk at T0+(k+1)*HALF_DIV.
  - Even k is the leading edge; odd k is the trailing edge.
  - CPHA=0: sample miso into the shift register on leading edges; shift the next bit onto mosi on trailing edges, except the final trailing edge.
  - CPHA=1: shift a bit onto mosi on leading edges, MSB at k=0; sample miso on trailing edges.
  - "Sample" means miso is registered in the same clk cycle in which sclk toggles.
- HOLD (1 tick):
  - sclk is back at cpol; cs_n stays low; mosi holds.
  - cs_n returns to all 1s at T0+(2*DATA_W+2)*HALF_DIV.
- GAP (1 tick):
  - cs_n high; busy=1.
  - At T0+(2*DATA_W+3)*HALF_DIV: state=IDLE, busy=0, done=1 for one cycle, rx_data = shifted word, mosi=0.
  - A start sampled in this done cycle is accepted, giving back-to-back transfers with a CS-high gap of HALF_DIV cycles.
- Example: DATA_W=8, HALF_DIV=2 gives cs_n rising at T0+36 and done at T0+38.
- start while busy is ignored and never queued. Changes to cpol/cpha/cs_sel/tx_data while busy have no effect.
- cs_sel ≥ N_CS: the transfer runs with full timing, but no cs_n bit asserts.
- miso is used as given; synchronisation is outside this block.

Decomposition:
- Shared SPI package or include holds:
  - state encodings IDLE/SETUP/XFER/HOLD/GAP;
  - mode constants MODE0..MODE3 as {cpol,cpha};
  - an edge-count width function.
- One natural sub-module, spi_tick_gen: a HALF_DIV counter with a restart input and a one-cycle tick output.

Test Plan:
- Mode 0, DATA_W=8, HALF_DIV=2, tx_data=0xA5, miso looped to mosi -> rx_data=0xA5; cs_n low T0..T0+36; done at T0+38; 8 rising sclk edges.
- Mode 3 (cpol=1, cpha=1), tx_data=0x3C, slave model returns 0xC3 on its falling edges -> sclk idles 1; mosi changes only on falling edges; rx_data=0xC3.
- Busy rejection: start=1 held through transfer, tx_data changed to 0xFF at T0+10 -> first transfer sends original 0x5A; second transfer begins at the done cycle (T0+38); cs_n high for exactly 2 cycles between transfers.
- Chip select decode, N_CS=4: cs_sel=2 -> cs_n=4'b1011 during transfer. cs_sel=5 (CS_W=3) -> cs_n=4'b1111 throughout, done still at T0+38.
- Reset mid-operation: rst=1 at T0+11 -> same cycle gives cs_n=all 1s, sclk=0, busy=0, rx_data=0. A new start after release gives a clean full transfer.
- HALF_DIV=1, modes 1 and 2, tx_data=0x81, loopback -> rx_data=0x81; done at T0+19.
